oled_layer_animator: RTL and testbench

- Parametrised successor to the single-task OLED pattern block.
- Drives oled_data for the 96x64 Oled_Display from pixel_index.
- Renders N_LAYERS independently animated squares, each in its own horizontal band, each sliding right and wrapping.
- Two debounced buttons select a layer and start/stop it; sits between the button inputs and the OLED driver in the top level.

---
 rtl/oled_anim_pkg.sv | 27 ++
 rtl/oled_layer_animator_btn_debounce.sv | 78 +++++++
 rtl/oled_layer_animator.sv | 98 +++++++++
 tb/tb_oled_layer_animator.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/oled_anim_pkg.sv
// rtl/oled_anim_pkg.sv - colours, layer palette, debounce states and display defaults for the layer animator
package oled_anim_pkg;

    localparam int OLED_W = 96;
    localparam int OLED_H = 64;

    localparam logic [15:0] BLACK   = 16'h0000;
    localparam logic [15:0] WHITE   = 16'hFFFF;
    localparam logic [15:0] RED     = 16'hF800;
    localparam logic [15:0] GREEN   = 16'h07E0;
    localparam logic [15:0] BLUE    = 16'h001F;
    localparam logic [15:0] YELLOW  = 16'hFFE0;
    localparam logic [15:0] CYAN    = 16'h07FF;
    localparam logic [15:0] MAGENTA = 16'hF81F;

    localparam logic [15:0] LAYER_COLOUR [8] = '{
        RED, GREEN, BLUE, YELLOW, CYAN, MAGENTA, WHITE, 16'hFD20
    };

    typedef enum logic {READY, LOCKOUT} deb_state_t;

    // Distance from b forward to a on a ring of m columns.
    function automatic int wrap_diff(input int a, input int b, input int m);
        return (a >= b) ? (a - b) : (a + m - b);
    endfunction

endpackage

// File: rtl/oled_layer_animator_btn_debounce.sv
// rtl/oled_layer_animator_btn_debounce.sv - button sync, rising-edge detect and shared lockout FSM
module btn_debounce
    import oled_anim_pkg::*;
#(
    parameter int DEBOUNCE = 20_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn_next,
    input  logic i_btn_go,
    output logic o_next_pulse,
    output logic o_go_pulse
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [1:0]    r_sync_n, r_sync_g;
    logic          r_prev_n, r_prev_g;
    logic          r_fill, r_armed_n, r_armed_g;
    logic [CW-1:0] r_cnt;
    deb_state_t    r_state, w_state_next;
    logic          w_edge_n, w_edge_g, w_accept;

    // A button must be seen released after reset before its edges count.
    assign w_edge_n = r_sync_n[1] & ~r_prev_n & r_armed_n;
    assign w_edge_g = r_sync_g[1] & ~r_prev_g & r_armed_g;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync_n  <= '0;
            r_sync_g  <= '0;
            r_prev_n  <= 1'b0;
            r_prev_g  <= 1'b0;
            r_fill    <= 1'b0;
            r_armed_n <= 1'b0;
            r_armed_g <= 1'b0;
            r_state   <= READY;
            r_cnt     <= '0;
        end else begin
            r_sync_n  <= {r_sync_n[0], i_btn_next};
            r_sync_g  <= {r_sync_g[0], i_btn_go};
            r_prev_n  <= r_sync_n[1];
            r_prev_g  <= r_sync_g[1];
            r_fill    <= 1'b1;
            r_armed_n <= r_armed_n | (r_fill & ~r_sync_n[0]);
            r_armed_g <= r_armed_g | (r_fill & ~r_sync_g[0]);
            r_state   <= w_state_next;
            if (w_accept) begin
                r_cnt <= '0;
            end else if (r_state == LOCKOUT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            READY: begin
                if (w_edge_n | w_edge_g) begin
                    w_accept     = 1'b1;
                    w_state_next = LOCKOUT;
                end
            end
            LOCKOUT: begin
                if (r_cnt == CW'(DEBOUNCE - 1)) begin
                    w_state_next = READY;
                end
            end
            default: w_state_next = READY;
        endcase
    end

    assign o_next_pulse = w_accept & w_edge_n;
    assign o_go_pulse   = w_accept & w_edge_g;

endmodule

// File: rtl/oled_layer_animator.sv
// rtl/oled_layer_animator.sv - N sliding squares in horizontal bands; SEL_OUTLINE_EN adds a white ring on the selected layer
module oled_layer_animator
    import oled_anim_pkg::*;
#(
    parameter int WIDTH    = OLED_W,
    parameter int HEIGHT   = OLED_H,
    parameter int N_LAYERS = 4,
    parameter int SQ_SIZE  = 10,
    parameter int TICK_DIV = 10_000_000,
    parameter int DEBOUNCE = 20_000_000,
    parameter int SEL_W    = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_next,
    input  logic                btn_go,
    input  logic [12:0]         pixel_index,
    output logic [15:0]         oled_data,
    output logic [SEL_W-1:0]    sel,
    output logic [N_LAYERS-1:0] running
);

    localparam int P  = HEIGHT / N_LAYERS;
    localparam int XW = $clog2(WIDTH);
    localparam int TW = $clog2(TICK_DIV + 1);

    logic [SEL_W-1:0]    r_sel;
    logic [N_LAYERS-1:0] r_running;
    logic [XW-1:0]       r_x_pos [N_LAYERS];
    logic [TW-1:0]       r_tick_cnt;
    logic [15:0]         r_oled;
    logic                w_tick, w_next_pulse, w_go_pulse;
    logic [15:0]         w_pix;
    int                  w_px, w_x, w_y;

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_btn_next   (btn_next),
        .i_btn_go     (btn_go),
        .o_next_pulse (w_next_pulse),
        .o_go_pulse   (w_go_pulse)
    );

    assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

    // Tick, toggle and sel all read pre-edge values, so go acts on the old sel.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel      <= '0;
            r_running  <= '0;
            r_tick_cnt <= '0;
            for (int i = 0; i < N_LAYERS; i++) r_x_pos[i] <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_go_pulse) r_running[r_sel] <= ~r_running[r_sel];
            if (w_next_pulse) r_sel <= (r_sel == SEL_W'(N_LAYERS - 1)) ? '0 : r_sel + 1'b1;
            for (int i = 0; i < N_LAYERS; i++) begin
                if (w_tick && r_running[i]) begin
                    r_x_pos[i] <= (r_x_pos[i] == XW'(WIDTH - 1)) ? '0 : r_x_pos[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_pix = BLACK;
        w_px  = int'(pixel_index);
        w_x   = w_px % WIDTH;
        w_y   = w_px / WIDTH;
        if (w_px < WIDTH * HEIGHT) begin
            for (int i = 0; i < N_LAYERS; i++) begin
                if (w_y >= i * P && w_y < i * P + SQ_SIZE &&
                    wrap_diff(w_x, int'(r_x_pos[i]), WIDTH) < SQ_SIZE) begin
                    w_pix = LAYER_COLOUR[i];
`ifdef SEL_OUTLINE_EN
                    if (int'(r_sel) == i &&
                        (w_y == i * P || w_y == i * P + SQ_SIZE - 1 ||
                         wrap_diff(w_x, int'(r_x_pos[i]), WIDTH) == 0 ||
                         wrap_diff(w_x, int'(r_x_pos[i]), WIDTH) == SQ_SIZE - 1)) begin
                        w_pix = WHITE;
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_oled <= BLACK;
        else       r_oled <= w_pix;
    end

    assign oled_data = r_oled;
    assign sel       = r_sel;
    assign running   = r_running;

endmodule

// File: tb/tb_oled_layer_animator.sv
// tb/tb_oled_layer_animator.sv - directed self-checking bench for oled_layer_animator
module tb_oled_layer_animator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_next = 1'b0;
    logic        btn_go = 1'b0;
    logic [12:0] pixel_index = '0;
    logic [15:0] oled_data;
    logic [1:0]  sel;
    logic [3:0]  running;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef SEL_OUTLINE_EN
    localparam logic [15:0] SEL_EDGE = 16'hFFFF;
`else
    localparam logic [15:0] SEL_EDGE = 16'hF800;
`endif

    oled_layer_animator #(.N_LAYERS(4), .SQ_SIZE(10), .TICK_DIV(4), .DEBOUNCE(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_next    (btn_next),
        .btn_go      (btn_go),
        .pixel_index (pixel_index),
        .oled_data   (oled_data),
        .sel         (sel),
        .running     (running)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
    endtask

    task automatic press(input logic nx, input logic go);
        btn_next = nx;
        btn_go   = go;
        cyc(1);
        btn_next = 1'b0;
        btn_go   = 1'b0;
    endtask

    task automatic test_reset();
        pixel_index = 13'd0;
        do_reset();
        n_tests++; if (oled_data !== 16'h0000) begin n_fail++; $display("FAIL reset_oled got %h want 0000", oled_data); end
        n_tests++; if (sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got %0d want 0", sel); end
        n_tests++; if (running !== 4'b0000) begin n_fail++; $display("FAIL reset_running got %b want 0000", running); end
        cyc(1);
        n_tests++; if (oled_data !== SEL_EDGE) begin n_fail++; $display("FAIL pix0 got %h want %h", oled_data, SEL_EDGE); end
        pixel_index = 13'd97; cyc(1);
        n_tests++; if (oled_data !== 16'hF800) begin n_fail++; $display("FAIL pix_1_1 got %h want F800", oled_data); end
        pixel_index = 13'd1536; cyc(1);
        n_tests++; if (oled_data !== 16'h07E0) begin n_fail++; $display("FAIL layer1_origin got %h want 07E0", oled_data); end
        pixel_index = 13'd6143; cyc(1);
        n_tests++; if (oled_data !== 16'h0000) begin n_fail++; $display("FAIL last_pix got %h want 0000", oled_data); end
        pixel_index = 13'd6144; cyc(1);
        n_tests++; if (oled_data !== 16'h0000) begin n_fail++; $display("FAIL out_of_range got %h want 0000", oled_data); end
    endtask

    // Edge k after reset release: x_pos of a layer started at E6 is k/4-1.
    task automatic test_go();
        do_reset();
        cyc(3);
        press(1'b0, 1'b1);
        cyc(3);
        n_tests++; if (running !== 4'b0001) begin n_fail++; $display("FAIL go_running got %b want 0001", running); end
        cyc(13);
        pixel_index = 13'd4; cyc(1);
        n_tests++; if (oled_data !== SEL_EDGE) begin n_fail++; $display("FAIL x4_pix4 got %h want %h", oled_data, SEL_EDGE); end
        pixel_index = 13'd3; cyc(1);
        n_tests++; if (oled_data !== 16'h0000) begin n_fail++; $display("FAIL x4_pix3 got %h want 0000", oled_data); end
    endtask

    task automatic test_wrap();
        int cols [10] = '{90, 91, 92, 93, 94, 95, 0, 1, 2, 3};
        cyc(341);
        press(1'b0, 1'b1);
        cyc(4);
        n_tests++; if (running !== 4'b0000) begin n_fail++; $display("FAIL stop_running got %b want 0000", running); end
        for (int k = 0; k < 10; k++) begin
            pixel_index = 13'(cols[k]); cyc(1);
`ifdef SEL_OUTLINE_EN
            n_tests++; if (oled_data !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_col%0d got %h want FFFF", cols[k], oled_data); end
`else
            n_tests++; if (oled_data !== 16'hF800) begin n_fail++; $display("FAIL wrap_col%0d got %h want F800", cols[k], oled_data); end
`endif
        end
        pixel_index = 13'd4; cyc(1);
        n_tests++; if (oled_data !== 16'h0000) begin n_fail++; $display("FAIL wrap_col4 got %h want 0000", oled_data); end
        pixel_index = 13'd572; cyc(1);
        n_tests++; if (oled_data !== 16'hF800) begin n_fail++; $display("FAIL wrap_interior got %h want F800", oled_data); end
    endtask

    task automatic test_sel();
        cyc(20);
        press(1'b1, 1'b0);
        cyc(1);
        press(1'b1, 1'b0);
        cyc(6);
        n_tests++; if (sel !== 2'd1) begin n_fail++; $display("FAIL sel_lockout got %0d want 1", sel); end
        cyc(20); press(1'b1, 1'b0); cyc(4);
        n_tests++; if (sel !== 2'd2) begin n_fail++; $display("FAIL sel_two got %0d want 2", sel); end
        cyc(20); press(1'b1, 1'b0); cyc(4);
        n_tests++; if (sel !== 2'd3) begin n_fail++; $display("FAIL sel_three got %0d want 3", sel); end
        cyc(20); press(1'b1, 1'b0); cyc(4);
        n_tests++; if (sel !== 2'd0) begin n_fail++; $display("FAIL sel_wrap got %0d want 0", sel); end
    endtask

    task automatic test_simultaneous();
        cyc(20); press(1'b1, 1'b0); cyc(20);
        n_tests++; if (sel !== 2'd1) begin n_fail++; $display("FAIL simul_pre_sel got %0d want 1", sel); end
        press(1'b1, 1'b1);
        cyc(3);
        n_tests++; if (running !== 4'b0010) begin n_fail++; $display("FAIL simul_running got %b want 0010", running); end
        n_tests++; if (sel !== 2'd2) begin n_fail++; $display("FAIL simul_sel got %0d want 2", sel); end
    endtask

    task automatic test_reset_mid_lockout();
        reset = 1'b1;
        cyc(1);
        n_tests++; if (sel !== 2'd0) begin n_fail++; $display("FAIL midrst_sel got %0d want 0", sel); end
        n_tests++; if (running !== 4'b0000) begin n_fail++; $display("FAIL midrst_running got %b want 0000", running); end
        n_tests++; if (oled_data !== 16'h0000) begin n_fail++; $display("FAIL midrst_oled got %h want 0000", oled_data); end
        reset = 1'b0;
        cyc(3);
        press(1'b0, 1'b1);
        cyc(3);
        n_tests++; if (running !== 4'b0001) begin n_fail++; $display("FAIL midrst_go got %b want 0001", running); end
    endtask

    initial begin
        test_reset();
        test_go();
        test_wrap();
        test_sel();
        test_simultaneous();
        test_reset_mid_lockout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
